background_raster_engine: RTL and testbench
===========================================

# background_raster_engine

Parametrised background/region fill engine. It walks a rectangular window of the frame in raster order, generates the ROM address for each pixel, and selects one of NUM_SRC image ROM outputs. Each colour is re-aligned with its own x/y so plot data is always coherent. It sits between the game-control FSM (start/mode/done handshake) and the VGA plotter mux, and supports both full-screen redraws and partial "erase behind sprite" redraws.

## Interface
Parameters:
- WIDTH, 160, frame width in pixels
- HEIGHT, 120, frame height in pixels
- X_W, 8, x coordinate width (≥ clog2(WIDTH))
- Y_W, 7, y coordinate width (≥ clog2(HEIGHT))
- ADDR_W, 15, ROM address width (≥ clog2(WIDTH*HEIGHT))
- COLOUR_W, 24, colour width per source
- NUM_SRC, 3, number of image ROMs (0 start, 1 game, 2 gameover)
- SRC_W, 2, source-select width
- ROM_LATENCY, 1, ROM address-to-q latency in cycles (1..4)

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- src_sel  in  SRC_W  image source, latched at start
- full_frame  in  1  1 = whole frame, 0 = use rect_*; latched at start
- rect_x, rect_y  in  X_W / Y_W  window origin, latched at start
- rect_w, rect_h  in  X_W / Y_W  window size in pixels, latched at start
- abort  in  1  cancel current fill (e.g. gameover)
- rom_address  out  ADDR_W  x + y*WIDTH of pixel being fetched
- rom_q  in  NUM_SRC*COLOUR_W  all ROM outputs concatenated, source k at bits [k*COLOUR_W +: COLOUR_W]
- plot  out  1  x_out/y_out/colour_out valid this cycle
- x_out, y_out  out  X_W / Y_W  pixel coordinate
- colour_out  out  COLOUR_W  pixel colour
- busy  out  1  high from accepted start until done/abort
- done  out  1  one-cycle pulse after the last plot

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: busy=0. On start=1, latch the parameters, compute the clipped window, go to SCAN, busy=1. Start while busy is ignored.
- Clipping: x_end = min(rect_x+rect_w, WIDTH), y_end = min(rect_y+rect_h, HEIGHT), computed one bit wider than X_W/Y_W so there is no wrap. full_frame forces origin 0,0 and size WIDTH×HEIGHT.
- Empty window: rect_w=0, rect_h=0, or origin off-screen. No SCAN; done pulses the cycle after start; no plots.
- src_sel ≥ NUM_SRC selects source 0.
- SCAN: issue one address per cycle. x increments each cycle. At x_end-1, x returns to the origin and y increments. After issuing (x_end-1, y_end-1), go to DRAIN.
- Alignment pipeline: x, y and a valid bit are delayed ROM_LATENCY stages. colour_out = selected slice of rom_q, registered together with the delayed x/y. There is no mismatch between the address and the reported coordinate.
- DRAIN: wait for the pipeline to empty. Assert done for one cycle with the final plot deasserted, then go to IDLE.
- abort (any state): go to IDLE next cycle and flush the pipeline valid bits, so plot=0 from the next cycle. No done. abort has priority over start in the same cycle.
- rom_address holds its last value while idle. It is don't-care when the pipeline is invalid.

## Timing
- Reset values: plot=0, busy=0, done=0, x_out=0, y_out=0, colour_out=0, rom_address=0, state IDLE, pipeline invalid.
- Start accepted at edge T: first address is valid after T. The first plot is asserted ROM_LATENCY+1 cycles after that address.
- Throughput: 1 pixel/clock. A full frame is WIDTH*HEIGHT plot cycles, consecutive and with no gaps.
- done is asserted the cycle after the last plot=1. busy falls with done.
- New start is accepted the cycle after done.
- Reset mid-fill clears everything immediately, asynchronously.

## Test plan
- Full frame, src_sel=1, ROM_LATENCY=1, ROM model q = address: plot high for exactly 19200 consecutive cycles; every colour_out equals x_out+160*y_out; last plot at (159,119); done one cycle later.
- Rect (150,110,20,20), src 2: window clipped to x 150..159, y 110..119; exactly 100 plots in raster order; colour from source-2 slice.
- rect_w=0: done pulses the cycle after start; zero plots; busy high for 1 cycle at most.
- abort asserted at plot #500 of a full frame: plot=0 from the next cycle; no done; a following start completes normally from (0,0).
- ROM_LATENCY=3 plus start re-asserted while busy: coordinate/colour match holds; second start is ignored; plot count is unchanged.
- resetn pulsed low mid-scan: all outputs are immediately at their reset values; IDLE after release.

Source files
------------

// File: rtl/background_raster_engine.sv
// background_raster_engine: walks a clipped window in raster order, drives the ROM address and
// emits each pixel's colour together with its own x/y after the ROM latency.
module background_raster_engine #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int ADDR_W      = 15,
    parameter int COLOUR_W    = 24,
    parameter int NUM_SRC     = 3,
    parameter int SRC_W       = 2,
    parameter int ROM_LATENCY = 1
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [SRC_W-1:0]             src_sel,
    input  logic                         full_frame,
    input  logic [X_W-1:0]               rect_x,
    input  logic [Y_W-1:0]               rect_y,
    input  logic [X_W-1:0]               rect_w,
    input  logic [Y_W-1:0]               rect_h,
    input  logic                         abort,
    output logic [ADDR_W-1:0]            rom_address,
    input  logic [NUM_SRC*COLOUR_W-1:0]  rom_q,
    output logic                         plot,
    output logic [X_W-1:0]               x_out,
    output logic [Y_W-1:0]               y_out,
    output logic [COLOUR_W-1:0]          colour_out,
    output logic                         busy,
    output logic                         done
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    state_t state, state_n;
    logic [X_W-1:0] x0, cx, sx, nx;
    logic [Y_W-1:0] cy, sy, ny;
    logic [X_W:0] x_end, sx_end, x_sum;
    logic [Y_W:0] y_end, sy_end, y_sum;
    logic [SRC_W-1:0] src;
    logic empty, last_x, last, done_n;
    logic [X_W-1:0] px [ROM_LATENCY];
    logic [Y_W-1:0] py [ROM_LATENCY];
    logic [ROM_LATENCY-1:0] pv;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return ADDR_W'(x) + ADDR_W'(y) * ADDR_W'(WIDTH);
    endfunction

    // Window ends are one bit wider than the coordinates so origin+size never wraps.
    always_comb begin
        x_sum  = {1'b0, rect_x} + {1'b0, rect_w};
        y_sum  = {1'b0, rect_y} + {1'b0, rect_h};
        sx     = full_frame ? '0 : rect_x;
        sy     = full_frame ? '0 : rect_y;
        sx_end = (full_frame || x_sum > (X_W+1)'(WIDTH)) ? (X_W+1)'(WIDTH) : x_sum;
        sy_end = (full_frame || y_sum > (Y_W+1)'(HEIGHT)) ? (Y_W+1)'(HEIGHT) : y_sum;
        empty  = (sx_end <= {1'b0, sx}) || (sy_end <= {1'b0, sy});
        last_x = ({1'b0, cx} + (X_W+1)'(1)) == x_end;
        nx     = last_x ? x0 : cx + X_W'(1);
        ny     = last_x ? cy + Y_W'(1) : cy;
        last   = last_x && (({1'b0, cy} + (Y_W+1)'(1)) == y_end);
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        if (abort)
            state_n = IDLE;
        else if (state == IDLE && start) begin
            state_n = empty ? IDLE : SCAN;
            done_n  = empty;
        end else if (state == SCAN && last)
            state_n = DRAIN;
        else if (state == DRAIN && pv == '0 && plot) begin
            state_n = IDLE;
            done_n  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_n;
    end

    assign busy = state != IDLE;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            done        <= 1'b0;
            plot        <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            colour_out  <= '0;
            rom_address <= '0;
            x0          <= '0;
            cx          <= '0;
            cy          <= '0;
            x_end       <= '0;
            y_end       <= '0;
            src         <= '0;
            pv          <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
        end else begin
            done <= done_n;
            if (!abort && state == IDLE && start && !empty) begin
                x0          <= sx;
                cx          <= sx;
                cy          <= sy;
                x_end       <= sx_end;
                y_end       <= sy_end;
                src         <= (int'(src_sel) >= NUM_SRC) ? '0 : src_sel;
                rom_address <= addr_of(sx, sy);
            end else if (state == SCAN && !last) begin
                cx          <= nx;
                cy          <= ny;
                rom_address <= addr_of(nx, ny);
            end
            // Coordinates travel alongside the ROM so each colour meets its own x/y.
            pv[0] <= state == SCAN && !abort;
            px[0] <= cx;
            py[0] <= cy;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pv[i] <= pv[i-1] && !abort;
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
            plot       <= pv[ROM_LATENCY-1] && !abort;
            x_out      <= px[ROM_LATENCY-1];
            y_out      <= py[ROM_LATENCY-1];
            colour_out <= rom_q[int'(src)*COLOUR_W +: COLOUR_W];
        end
    end
endmodule

// File: tb/tb_background_raster_engine.sv
// tb_background_raster_engine: directed vectors run through ROM_LATENCY=1 and =3 instances side by side.
module tb_background_raster_engine;
    typedef struct {
        logic       fr;
        logic [7:0] rx;
        logic [6:0] ry;
        logic [7:0] rw;
        logic [6:0] rh;
        logic [1:0] src;
        int         es;
        int         xl, xh, yl, yh, n;
        logic       poke;
    } vec_t;

    logic clock = 1'b0, resetn = 1'b0, start = 1'b0, full_frame = 1'b0, abort = 1'b0;
    logic [1:0] src_sel = '0;
    logic [7:0] rect_x = '0, rect_w = '0;
    logic [6:0] rect_y = '0, rect_h = '0;
    logic [14:0] addr_w [2];
    logic [71:0] rq [2];
    logic plot_w [2], busy_w [2], done_w [2];
    logic [7:0] x_w [2];
    logic [6:0] y_w [2];
    logic [23:0] col_w [2];
    logic [14:0] a1;
    logic [14:0] a3 [3];

    int cyc = 0, n_chk = 0, n_fail = 0, es = 0;
    int cnt [2], bad [2], dn [2], first [2], last [2], dcyc [2], bz [2], lx [2], ly [2], ex [2], ey [2];
    int xl = 0, xh = 0, yl = 0;
    vec_t tbl [8];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    background_raster_engine #(.ROM_LATENCY(1)) dut1 (
        .clock(clock), .resetn(resetn), .start(start), .src_sel(src_sel), .full_frame(full_frame),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h), .abort(abort),
        .rom_address(addr_w[0]), .rom_q(rq[0]), .plot(plot_w[0]), .x_out(x_w[0]), .y_out(y_w[0]),
        .colour_out(col_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    background_raster_engine #(.ROM_LATENCY(3)) dut3 (
        .clock(clock), .resetn(resetn), .start(start), .src_sel(src_sel), .full_frame(full_frame),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h), .abort(abort),
        .rom_address(addr_w[1]), .rom_q(rq[1]), .plot(plot_w[1]), .x_out(x_w[1]), .y_out(y_w[1]),
        .colour_out(col_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    function automatic logic [71:0] rom_word(input logic [14:0] a);
        return {24'(3 << 16) | 24'(a), 24'(2 << 16) | 24'(a), 24'(1 << 16) | 24'(a)};
    endfunction

    always @(posedge clock) begin
        a1    <= addr_w[0];
        a3[0] <= addr_w[1];
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign rq[0] = rom_word(a1);
    assign rq[1] = rom_word(a3[2]);

    function automatic logic [23:0] exp_col(input int x, input int y);
        return 24'((es + 1) << 16) | 24'(x + 160 * y);
    endfunction

    // Plot monitor: raster order against a walking expected pointer, colour against x/y.
    always @(negedge clock) begin
        if (resetn) begin
            for (int k = 0; k < 2; k++) begin
                if (plot_w[k]) begin
                    if (cnt[k] == 0) first[k] = cyc;
                    last[k] = cyc;
                    cnt[k]++;
                    lx[k] = int'(x_w[k]);
                    ly[k] = int'(y_w[k]);
                    if (lx[k] != ex[k] || ly[k] != ey[k] || col_w[k] != exp_col(lx[k], ly[k])) bad[k]++;
                    ex[k]++;
                    if (ex[k] > xh) begin
                        ex[k] = xl;
                        ey[k]++;
                    end
                end
                if (done_w[k]) begin
                    dn[k]++;
                    dcyc[k] = cyc;
                    bz[k] = int'(busy_w[k]);
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string nm);
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s_L%0d", nm, k ? 3 : 1),
                longint'({plot_w[k], busy_w[k], done_w[k], x_w[k], y_w[k], col_w[k], addr_w[k]}), 0);
    endtask

    task automatic arm(input vec_t v);
        es = v.es; xl = v.xl; xh = v.xh; yl = v.yl;
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; bad[k] = 0; dn[k] = 0; first[k] = -1; last[k] = -1;
            dcyc[k] = -1; bz[k] = -1; lx[k] = -1; ly[k] = -1; ex[k] = v.xl; ey[k] = v.yl;
        end
    endtask

    task automatic launch(input vec_t v, output int t0);
        @(negedge clock);
        full_frame = v.fr; rect_x = v.rx; rect_y = v.ry; rect_w = v.rw; rect_h = v.rh;
        src_sel = v.src; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int t0, lat;
        arm(v);
        launch(v, t0);
        if (v.poke) begin
            repeat (3) @(negedge clock);
            full_frame = 1'b0; rect_x = 8'd0; rect_y = 7'd0; rect_w = 8'd50; rect_h = 7'd50;
            src_sel = 2'd1; start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        for (int i = 0; i < 25000 && !(dn[0] > 0 && dn[1] > 0); i++) @(posedge clock);
        repeat (5) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            lat = k ? 3 : 1;
            chk($sformatf("%s_L%0d_count", nm, lat), cnt[k], v.n);
            chk($sformatf("%s_L%0d_order_colour_errs", nm, lat), bad[k], 0);
            chk($sformatf("%s_L%0d_done_pulses", nm, lat), dn[k], 1);
            chk($sformatf("%s_L%0d_busy_at_done", nm, lat), bz[k], 0);
            if (v.n > 0) begin
                chk($sformatf("%s_L%0d_first_plot_cycle", nm, lat), first[k], t0 + lat + 1);
                chk($sformatf("%s_L%0d_plot_span", nm, lat), last[k] - first[k] + 1, v.n);
                chk($sformatf("%s_L%0d_last_xy", nm, lat), lx[k] * 1000 + ly[k], v.xh * 1000 + v.yh);
                chk($sformatf("%s_L%0d_done_cycle", nm, lat), dcyc[k], last[k] + 1);
            end else
                chk($sformatf("%s_L%0d_empty_done_cycle", nm, lat), dcyc[k], t0);
        end
    endtask

    initial begin
        int ta, t0;
        vec_t vf, vs;
        tbl[0] = '{1'b1, 8'd0,   7'd0,   8'd0,  7'd0,  2'd1, 1, 0,   159, 0,   119, 19200, 1'b0};
        tbl[1] = '{1'b0, 8'd150, 7'd110, 8'd20, 7'd20, 2'd2, 2, 150, 159, 110, 119, 100,   1'b0};
        tbl[2] = '{1'b0, 8'd10,  7'd20,  8'd5,  7'd3,  2'd3, 0, 10,  14,  20,  22,  15,    1'b1};
        tbl[3] = '{1'b0, 8'd5,   7'd5,   8'd0,  7'd7,  2'd1, 1, 0,   0,   0,   0,   0,     1'b0};
        tbl[4] = '{1'b0, 8'd160, 7'd0,   8'd4,  7'd4,  2'd1, 1, 0,   0,   0,   0,   0,     1'b0};
        tbl[5] = '{1'b0, 8'd0,   7'd0,   8'd4,  7'd0,  2'd2, 2, 0,   0,   0,   0,   0,     1'b0};
        tbl[6] = '{1'b0, 8'd159, 7'd119, 8'd1,  7'd1,  2'd1, 1, 159, 159, 119, 119, 1,     1'b0};
        tbl[7] = '{1'b1, 8'd50,  7'd50,  8'd0,  7'd0,  2'd0, 0, 0,   159, 0,   119, 19200, 1'b0};
        vf = tbl[0];
        vs = '{1'b0, 8'd0, 7'd0, 8'd4, 7'd2, 2'd2, 2, 0, 3, 0, 1, 8, 1'b0};

        repeat (3) @(negedge clock);
        chk_rst("reset_values");
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        arm(vf);
        launch(vf, t0);
        for (int i = 0; i < 5000 && cnt[0] < 500; i++) @(posedge clock);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        ta = cyc;
        repeat (10) @(negedge clock);
        chk("abort_L1_count", cnt[0], 501);
        chk("abort_L3_count", cnt[1], 499);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("abort_L%0d_no_plot_after", k ? 3 : 1), last[k] < ta, 1);
            chk($sformatf("abort_L%0d_no_done", k ? 3 : 1), dn[k], 0);
            chk($sformatf("abort_L%0d_busy", k ? 3 : 1), busy_w[k], 0);
            chk($sformatf("abort_L%0d_errs", k ? 3 : 1), bad[k], 0);
        end
        run_vec(vs, "after_abort");

        arm(vf);
        launch(vf, t0);
        repeat (50) @(negedge clock);
        resetn = 1'b0;
        #1;
        chk_rst("mid_reset");
        chk("mid_reset_L1_errs", bad[0], 0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 2; k++)
            chk($sformatf("after_reset_L%0d_idle", k ? 3 : 1), {busy_w[k], plot_w[k]}, 0);
        run_vec(vs, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
